bus_share_arbiter: RTL and testbench

Round-robin arbiter that shares the CPU's 32-bit, 4-source shared bus among four requesters (e.g. fetch, load/store, DMA, debug). It registers a one-hot grant, drives the 2-bit `selection` of the existing `quadrupleMux` data path, and holds ownership until the owner signals `done`, drops its request, or exceeds a hold-cycle timeout. A one-cycle turnaround separates owners.

---
 rtl/bus_share_arbiter_pkg.sv | 38 +++
 rtl/bus_share_arbiter_mux.sv | 33 +++
 rtl/bus_share_arbiter.sv | 118 +++++++++++
 tb/tb_bus_share_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_share_arbiter_pkg
// Shared CPU package for the shared-bus arbiter.
// Contents:
//   NUM_REQ              number of requesters sharing the bus
//   ST_IDLE/GRANT/TURN   arbiter state encoding (2-bit, legacy-compatible)
//   rr_pick()            round-robin priority scan
// ---------------------------------------------------------------------------
package bus_share_arbiter_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // Returns the first requester with its bit set, scanning upward from
    // ptr+1 and wrapping modulo NUM_REQ. The last owner is therefore the
    // lowest priority on the next arbitration. When req is all zero the
    // result is ptr, and the caller must not use it.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'(int'(ptr) + k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_share_arbiter_mux.sv
// ---------------------------------------------------------------------------
// quadrupleMux
// Existing 4:1 data-path multiplexer used by the shared bus.
// Ports:
//   selection            2-bit source select (0 -> input_a ... 3 -> input_d)
//   input_a..input_d     WIDTH-bit source data
//   output_y             WIDTH-bit selected data (combinational)
// ---------------------------------------------------------------------------
module quadrupleMux #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       selection,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic [WIDTH-1:0] input_d,
    output logic [WIDTH-1:0] output_y
);

    // Pure combinational select; all four encodings are covered, so the
    // default is never reached and only guards against X on selection.
    always_comb begin
        output_y = input_a;
        case (selection)
            2'd0:    output_y = input_a;
            2'd1:    output_y = input_b;
            2'd2:    output_y = input_c;
            2'd3:    output_y = input_d;
            default: output_y = input_a;
        endcase
    end

endmodule

// File: rtl/bus_share_arbiter.sv
// ---------------------------------------------------------------------------
// bus_share_arbiter
// Round-robin arbiter sharing the CPU's 4-source bus. Ownership is held until
// the owner signals done, drops its request, or reaches TIMEOUT grant cycles.
// A single TURN cycle separates consecutive owners.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   request[3:0]          per-requester bus request
//   done[3:0]             per-requester end of transfer (owner's bit only)
//   data_a..data_d        source data of requesters 0..3
//   grant[3:0]            registered one-hot grant, 0 when the bus is free
//   selection[1:0]        registered index of the current/last owner
//   bus_data              mux output selected by selection
//   bus_valid             high exactly while in GRANT
//   timeout_flag          one-cycle pulse when ownership is revoked by timeout
// ---------------------------------------------------------------------------
module bus_share_arbiter
    import bus_share_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    request,
    input  logic [NUM_REQ-1:0]    done,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [DATA_WIDTH-1:0] data_c,
    input  logic [DATA_WIDTH-1:0] data_d,
    output logic [NUM_REQ-1:0]    grant,
    output logic [1:0]            selection,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_valid,
    output logic                  timeout_flag
);

    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT);

    logic [1:0] state;
    logic [1:0] pointer;
    logic [7:0] hold_count;

    logic [1:0] winner;
    logic       owner_done;
    logic       owner_dropped;
    logic       hold_expired;
    logic       release_bus;

    // Release decode for the current owner, which is always the registered
    // selection while in GRANT. Bits belonging to other requesters are never
    // looked at. The flag is raised only when the timeout alone ends the
    // ownership, so a done or dropped request on the same edge suppresses it.
    always_comb begin
        winner        = rr_pick(request, pointer);
        owner_done    = done[selection];
        owner_dropped = !request[selection];
        hold_expired  = (hold_count == HOLD_LIMIT);
        release_bus   = owner_done || owner_dropped || hold_expired;
    end

    // Arbiter FSM with pointer, hold counter and the registered outputs.
    // Reset wins over every state, so an owner interrupted mid-GRANT simply
    // loses the bus with no timeout pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant        <= '0;
            selection    <= 2'd0;
            pointer      <= 2'd3;
            hold_count   <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (request != '0) begin
                        state      <= ST_GRANT;
                        grant      <= NUM_REQ'(1) << winner;
                        selection  <= winner;
                        hold_count <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (release_bus) begin
                        state        <= ST_TURN;
                        grant        <= '0;
                        pointer      <= selection;
                        timeout_flag <= hold_expired && !owner_done && !owner_dropped;
                    end else if (hold_count != 8'hFF) begin
                        hold_count <= hold_count + 8'd1;
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign bus_valid = (state == ST_GRANT);

    quadrupleMux #(
        .WIDTH(DATA_WIDTH)
    ) u_mux (
        .selection(selection),
        .input_a  (data_a),
        .input_b  (data_b),
        .input_c  (data_c),
        .input_d  (data_d),
        .output_y (bus_data)
    );

endmodule

// File: tb/tb_bus_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_share_arbiter
// Scoreboard bench for bus_share_arbiter (TIMEOUT = 4). Every driven cycle
// runs a behavioural ownership model; its expected outputs are queued with
// the clock edge they belong to, and a monitor on the falling edge pops and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_bus_share_arbiter;

    localparam int DW      = 32;
    localparam int TMO     = 4;
    localparam int NRANDOM = 3000;

    logic          clock;
    logic          reset;
    logic [3:0]    request;
    logic [3:0]    done;
    logic [DW-1:0] data_a, data_b, data_c, data_d;
    logic [3:0]    grant;
    logic [1:0]    selection;
    logic [DW-1:0] bus_data;
    logic          bus_valid;
    logic          timeout_flag;

    typedef struct {
        int         target;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       flag;
    } exp_t;

    exp_t expQ[$];
    exp_t monItem;

    int checks = 0;
    int errors = 0;
    int edgeCount = 0;
    int timeoutsSeen = 0;

    // Behavioural model: who owns the bus, for how long, and who owned it last
    int mOwner = -1;
    int mHold  = 0;
    int mLast  = 0;
    int mPtr   = 3;
    int mTurn  = 0;
    int mFlag  = 0;

    bus_share_arbiter #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .done        (done),
        .data_a      (data_a),
        .data_b      (data_b),
        .data_c      (data_c),
        .data_d      (data_d),
        .grant       (grant),
        .selection   (selection),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .timeout_flag(timeout_flag)
    );

    // Free-running 10-time-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count rising edges so queued expectations can be matched to the edge
    // after which they become visible
    always @(posedge clock) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h",
                     name, edgeCount, actual, expected);
        end
    endtask

    // One step of the ownership model for the inputs seen at the next edge
    task automatic modelStep(input logic [3:0] req, input logic [3:0] dn,
                             input logic rst);
        if (rst) begin
            mOwner = -1; mHold = 0; mLast = 0; mPtr = 3; mTurn = 0; mFlag = 0;
        end else if (mTurn != 0) begin
            mTurn = 0;
            mFlag = 0;
        end else if (mOwner >= 0) begin
            if (dn[mOwner] || !req[mOwner] || mHold == TMO) begin
                mFlag  = (!dn[mOwner] && req[mOwner]) ? 1 : 0;
                mPtr   = mOwner;
                mOwner = -1;
                mTurn  = 1;
            end else begin
                mHold++;
                mFlag = 0;
            end
        end else begin
            mFlag = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (mPtr + k) % 4;
                if (mOwner < 0 && req[c]) begin
                    mOwner = c;
                    mLast  = c;
                    mHold  = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, queue the model's view of the next edge,
    // then move to just after that edge
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] dn,
                                 input logic rst);
        exp_t e;
        request = req;
        done    = dn;
        reset   = rst;
        data_a  = $urandom;
        data_b  = $urandom;
        data_c  = $urandom;
        data_d  = $urandom;
        modelStep(req, dn, rst);
        e.target = edgeCount + 1;
        e.grant  = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        e.sel    = 2'(mLast);
        e.valid  = (mOwner >= 0);
        e.flag   = (mFlag != 0);
        if (e.flag) timeoutsSeen++;
        expQ.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every expectation whose edge has already happened
    always @(negedge clock) begin
        while (expQ.size() > 0 && expQ[0].target <= edgeCount) begin
            logic [DW-1:0] want;
            monItem = expQ.pop_front();
            case (monItem.sel)
                2'd0:    want = data_a;
                2'd1:    want = data_b;
                2'd2:    want = data_c;
                default: want = data_d;
            endcase
            checkOutput("grant", 32'(grant), 32'(monItem.grant));
            checkOutput("selection", 32'(selection), 32'(monItem.sel));
            checkOutput("bus_valid", 32'(bus_valid), 32'(monItem.valid));
            checkOutput("timeout_flag", 32'(timeout_flag), 32'(monItem.flag));
            checkOutput("bus_data", bus_data, want);
        end
    end

    // Directed scenarios first, then a long randomized run with occasional
    // resets, sticky requests and sporadic done pulses
    initial begin
        logic [3:0] req;
        logic [3:0] dn;
        request = '0; done = '0; reset = 1'b1;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;

        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (5) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Single requester 2 finishing with done on its third grant cycle
        repeat (3) applyStimulus(4'b0100, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // All four requesting, each owner done on its second grant cycle
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (20) begin
            dn = (mOwner >= 0 && mHold == 2) ? (4'b0001 << mOwner) : 4'b0000;
            applyStimulus(4'b1111, dn, 1'b0);
        end

        // Lone requester 1 held until timeout, twice
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (14) applyStimulus(4'b0010, 4'b0000, 1'b0);

        // Owner 3 drops its request after two cycles while 0 waits
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        mPtr = mPtr;
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        repeat (2) applyStimulus(4'b1001, 4'b0000, 1'b0);
        repeat (6) applyStimulus(4'b0001, 4'b0000, 1'b0);

        // Requester 1 reaching timeout and done together, then reset mid-GRANT
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (TMO) applyStimulus(4'b0010, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        repeat (3) applyStimulus(4'b0010, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        repeat (4) applyStimulus(4'b0001, 4'b0000, 1'b0);

        req = 4'b0000;
        for (int i = 0; i < NRANDOM; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            dn = '0;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) dn[b] = 1'b1;
            applyStimulus(req, dn, ($urandom_range(149) == 0));
        end

        applyStimulus(4'b0000, 4'b0000, 1'b0);
        @(negedge clock);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        if (timeoutsSeen == 0)
            $display("[TB] note: random run produced no timeout revocations");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
